ibex_load_store_resp: RTL and testbench

- Response stage between the data bus and writeback. It tracks the one load/store the LSU has in flight and collects one or two bus responses; two responses are needed for a misaligned access.
- For loads it aligns and sign- or zero-extends the read data. It then drives the writeback-side LSU interface: RF write enable and data, the response-valid pulse, and error pulses.
- Load data reaches writeback in the same cycle as the final bus response.

---
 rtl/ibex_load_store_resp.sv | 159 +++++++++++++++
 tb/tb_ibex_load_store_resp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_load_store_resp.sv
// LSU response stage: tracks one outstanding access, merges split responses,
// aligns and extends load data, and pulses writeback and error signals.
module ibex_load_store_resp #(
  parameter logic ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        rf_we_lsu_o,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LAST,
    WAIT_FIRST
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_we;
  logic        r_sign;
  logic [1:0]  r_type;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_split_in;
  logic        w_split_q;
  logic        w_word_q;
  logic        w_final;
  logic        w_latch;
  logic        w_err_all;
  logic [4:0]  w_sh;
  logic [5:0]  w_lsh;
  logic [31:0] w_raw;
  logic [31:0] w_ext;

  // Type 11 is handled like a word access.
  assign w_split_in =
    ((req_type_i == 2'b00 || req_type_i == 2'b11) && req_offset_i != 2'b00) ||
    (req_type_i == 2'b01 && req_offset_i == 2'b11);
  assign w_word_q  = (r_type == 2'b00) || (r_type == 2'b11);
  assign w_split_q = (w_word_q && r_off != 2'b00) ||
                     (r_type == 2'b01 && r_off == 2'b11);
  assign w_accept  = req_valid_i & req_ready_o;

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    w_final     = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          w_state_nxt = w_split_in ? WAIT_FIRST : WAIT_LAST;
      end
      WAIT_FIRST: begin
        if (data_rvalid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (data_rvalid_i) begin
          w_final     = 1'b1;
          req_ready_o = 1'b1;
          if (req_valid_i)
            w_state_nxt = w_split_in ? WAIT_FIRST : WAIT_LAST;
          else
            w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and captured request attributes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_type  <= 2'b00;
      r_off   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we   <= req_we_i;
        r_sign <= req_sign_ext_i;
        r_type <= req_type_i;
        r_off  <= req_offset_i;
      end
      if (w_latch)
        r_err <= data_err_i;
    end
  end

  // First half of a split access; cleared on reset only when ResetAll.
  always_ff @(posedge clk_i) begin
    if (ResetAll && rst_i)
      r_rdata <= 32'h0;
    else if (w_latch && !rst_i)
      r_rdata <= data_rdata_i;
  end

  assign w_sh  = {r_off, 3'b000};
  assign w_lsh = 6'd32 - {1'b0, w_sh};

  // Align the bus data, then extend to 32 bits by access size.
  always_comb begin
    w_raw = data_rdata_i >> w_sh;
    if (w_split_q && w_word_q)
      w_raw = (data_rdata_i << w_lsh) | (r_rdata >> w_sh);
    else if (w_split_q)
      w_raw = {16'h0, data_rdata_i[7:0], r_rdata[31:24]};
    w_ext = w_raw;
    unique case (1'b1)
      (r_type == 2'b10): w_ext = {{24{r_sign & w_raw[7]}}, w_raw[7:0]};
      (r_type == 2'b01): w_ext = {{16{r_sign & w_raw[15]}}, w_raw[15:0]};
      default:           w_ext = w_raw;
    endcase
  end

  assign w_err_all        = data_err_i | (w_split_q & r_err);
  assign lsu_resp_valid_o = w_final;
  assign load_err_o       = w_final & ~r_we & w_err_all;
  assign store_err_o      = w_final & r_we & w_err_all;
  assign rf_we_lsu_o      = w_final & ~r_we & ~w_err_all;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? w_ext : 32'h0;
  assign busy_o           = (r_state != IDLE);

  a_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({rf_we_lsu_o, load_err_o, store_err_o}));

  a_idle_quiet: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == IDLE) |-> !(lsu_resp_valid_o || rf_we_lsu_o ||
                            load_err_o || store_err_o));

  a_no_req_wf: assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_state == WAIT_FIRST && req_valid_i && req_ready_o));

endmodule

// File: tb/tb_ibex_load_store_resp.sv
// Bench for ibex_load_store_resp: directed test-plan cases with literal
// expectations, then random traffic checked against a byte-level model.
module tb_ibex_load_store_resp;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_type_i = 2'b00;
  logic        req_sign_ext_i = 1'b0;
  logic [1:0]  req_offset_i = 2'b00;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;
  logic        data_err_i = 1'b0;
  logic        rf_we_lsu_o;
  logic [31:0] rf_wdata_lsu_o;
  logic        lsu_resp_valid_o;
  logic        load_err_o;
  logic        store_err_o;
  logic        busy_o;

  int n_chk = 0;
  int n_err = 0;

  ibex_load_store_resp dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_type_i       (req_type_i),
    .req_sign_ext_i   (req_sign_ext_i),
    .req_offset_i     (req_offset_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .data_err_i       (data_err_i),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .load_err_o       (load_err_o),
    .store_err_o      (store_err_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: the outstanding access and what it still needs.
  bit          m_busy = 0;
  int          m_rem = 0;
  bit          m_we;
  bit [1:0]    m_ty;
  bit          m_sx;
  bit [1:0]    m_off;
  bit [31:0]   m_first;
  bit          m_ferr;

  function automatic bit is_split(bit [1:0] ty, bit [1:0] off);
    int nbytes;
    nbytes = (ty == 2'b01) ? 2 : (ty == 2'b10) ? 1 : 4;
    return (int'(off) + nbytes) > 4;
  endfunction

  // Bytes at addresses off..off+n-1 of the little-endian stream first,cur.
  function automatic bit [31:0] load_val(bit [1:0] ty, bit sx, bit [1:0] off,
                                         bit split, bit [31:0] first,
                                         bit [31:0] cur);
    bit [63:0] c;
    bit [31:0] v;
    c = split ? {cur, first} : {32'h0, cur};
    v = c[31:0];
    for (int b = 0; b < 4; b++)
      v[8*b +: 8] = c[8*(b + int'(off)) +: 8];
    if (ty == 2'b10) v = (sx && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
    if (ty == 2'b01) v = (sx && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive, compare against the model at negedge, advance model.
  task automatic step(bit rst, bit rv, bit we, bit [1:0] ty, bit sx,
                      bit [1:0] off, bit dv, bit [31:0] dd, bit de);
    bit        e_ready, e_final, e_err, e_split;
    bit [31:0] e_data;
    @(posedge clk_i);
    #1;
    rst_i          = rst;
    req_valid_i    = rv;
    req_we_i       = we;
    req_type_i     = ty;
    req_sign_ext_i = sx;
    req_offset_i   = off;
    data_rvalid_i  = dv;
    data_rdata_i   = dd;
    data_err_i     = de;
    @(negedge clk_i);
    e_split = m_busy && is_split(m_ty, m_off);
    e_ready = !m_busy || (m_rem == 1 && dv);
    e_final = m_busy && m_rem == 1 && dv;
    e_err   = de || (e_split && m_ferr);
    e_data  = load_val(m_ty, m_sx, m_off, e_split, m_first, dd);
    if (!rst) begin
      chk("req_ready", 32'(req_ready_o), 32'(e_ready));
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("resp_valid", 32'(lsu_resp_valid_o), 32'(e_final));
      chk("load_err", 32'(load_err_o), 32'(e_final && !m_we && e_err));
      chk("store_err", 32'(store_err_o), 32'(e_final && m_we && e_err));
      chk("rf_we", 32'(rf_we_lsu_o), 32'(e_final && !m_we && !e_err));
      chk("rf_wdata", rf_wdata_lsu_o,
          (e_final && !m_we && !e_err) ? e_data : 32'h0);
    end
    if (rst) begin
      m_busy = 0;
      m_rem  = 0;
      m_ferr = 0;
    end else begin
      if (m_busy && dv) begin
        if (m_rem == 2) begin
          m_first = dd;
          m_ferr  = de;
          m_rem   = 1;
        end else begin
          m_busy = 0;
          m_rem  = 0;
        end
      end
      if (rv && e_ready) begin
        m_busy = 1;
        m_we   = we;
        m_ty   = ty;
        m_sx   = sx;
        m_off  = off;
        m_rem  = is_split(ty, off) ? 2 : 1;
      end
    end
  endtask

  task automatic req(bit we, bit [1:0] ty, bit sx, bit [1:0] off);
    step(0, 1, we, ty, sx, off, 0, 32'h0, 0);
  endtask

  task automatic rsp(bit [31:0] dd, bit de);
    step(0, 0, 0, 2'b00, 0, 2'b00, 1, dd, de);
  endtask

  initial begin
    step(1, 0, 0, 2'b00, 0, 2'b00, 0, 32'h0, 0);
    step(1, 0, 0, 2'b00, 0, 2'b00, 0, 32'h0, 0);
    step(0, 0, 0, 2'b00, 0, 2'b00, 0, 32'h0, 0);
    chk("reset ready", 32'(req_ready_o), 32'h1);
    chk("reset busy", 32'(busy_o), 32'h0);

    req(0, 2'b00, 0, 2'd0);
    rsp(32'hDEADBEEF, 0);
    chk("lw wdata", rf_wdata_lsu_o, 32'hDEADBEEF);
    chk("lw rf_we", 32'(rf_we_lsu_o), 32'h1);
    chk("lw resp", 32'(lsu_resp_valid_o), 32'h1);

    req(0, 2'b10, 1, 2'd2);
    rsp(32'h00800000, 0);
    chk("lb signed", rf_wdata_lsu_o, 32'hFFFFFF80);
    req(0, 2'b10, 0, 2'd2);
    rsp(32'h00800000, 0);
    chk("lbu", rf_wdata_lsu_o, 32'h00000080);

    req(0, 2'b00, 0, 2'd1);
    rsp(32'h44332211, 0);
    chk("split w first resp", 32'(lsu_resp_valid_o), 32'h0);
    chk("split w first rf_we", 32'(rf_we_lsu_o), 32'h0);
    rsp(32'h88776655, 0);
    chk("split w wdata", rf_wdata_lsu_o, 32'h55443322);
    chk("split w resp", 32'(lsu_resp_valid_o), 32'h1);

    req(0, 2'b01, 1, 2'd3);
    rsp(32'hAA000000, 0);
    rsp(32'h000000BB, 0);
    chk("split lh", rf_wdata_lsu_o, 32'hFFFFBBAA);

    req(0, 2'b00, 0, 2'd2);
    rsp(32'h12345678, 1);
    rsp(32'h9ABCDEF0, 0);
    chk("split err load_err", 32'(load_err_o), 32'h1);
    chk("split err rf_we", 32'(rf_we_lsu_o), 32'h0);
    req(1, 2'b00, 0, 2'd0);
    rsp(32'h0, 1);
    chk("store err", 32'(store_err_o), 32'h1);
    chk("store err rf_we", 32'(rf_we_lsu_o), 32'h0);

    req(0, 2'b00, 0, 2'd0);
    step(0, 1, 0, 2'b10, 0, 2'd1, 1, 32'h11111111, 0);
    chk("b2b ready", 32'(req_ready_o), 32'h1);
    rsp(32'h0000AB00, 0);
    chk("b2b wdata", rf_wdata_lsu_o, 32'h000000AB);

    req(0, 2'b00, 0, 2'd3);
    step(1, 0, 0, 2'b00, 0, 2'd0, 0, 32'h0, 0);
    rsp(32'hCAFEF00D, 0);
    chk("rst wf resp", 32'(lsu_resp_valid_o), 32'h0);
    chk("rst wf busy", 32'(busy_o), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      bit rst, rv, dv;
      rst = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 1) == 1);
      dv  = m_busy ? ($urandom_range(0, 9) < 6)
                   : ($urandom_range(0, 19) == 0);
      step(rst, rv, 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
           dv, $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
